// File: rtl/prefetch_seq_pkg.sv
// ---------------------------------------------------------------------------
// prefetch_seq_pkg
// Shared definitions for the prefetch transaction sequencer:
//   - seq_state_e : sequencer FSM states
//   - STATUS_*    : job_status encodings reported to the register bank
// No ports (package).
// ---------------------------------------------------------------------------
package prefetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_e;

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_ERR     = 2'b01;
    localparam logic [1:0] STATUS_ABORT   = 2'b10;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

endpackage

// File: rtl/prefetch_edge_det.sv
// ---------------------------------------------------------------------------
// prefetch_edge_det
// Registered rising-edge detector. The previous level is held in a flop and
// rise_o is high in the cycle where din_i=1 and the stored level is 0, so a
// level that is already high produces no further edges.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset (stored level clears to 0)
//   din_i  : level input
//   rise_o : one-cycle rising-edge indication
// ---------------------------------------------------------------------------
module prefetch_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= din_i;
        end
    end

    assign rise_o = din_i & ~prev_q;

endmodule

// File: rtl/prefetch_txn_sequencer.sv
// ---------------------------------------------------------------------------
// prefetch_txn_sequencer
// Sequences the prefetch AXI master for a software job (base, stride, count):
// pulses txn_init once per transaction, waits for the TXN_DONE rising edge,
// samples ERROR, retries failed transactions up to MAX_RETRY times and
// reports done/error counts and job status.
//
// Optional build macro: PREFETCH_SEQ_TIMEOUT_EN
//   defined   -> WAIT watchdog of TIMEOUT_CYCLES cycles, status 11 on expiry
//   undefined -> WAIT lasts until the master completes
//
// Ports:
//   ACLK, ARESET              : clock / asynchronous active-high reset
//   cfg_start, cfg_abort      : single-cycle strobes from register bank
//   cfg_base_addr, cfg_stride : first address and per-transaction increment
//   cfg_count                 : number of transactions (0 = empty job)
//   txn_init, txn_addr        : launch pulse and target address to master
//   txn_done, txn_error       : completion level and error from master
//   busy, job_done            : job in progress / one-cycle end-of-job pulse
//   job_status                : 00 ok, 01 error, 10 aborted, 11 timeout
//   done_cnt, err_cnt         : saturating per-job transaction counters
// ---------------------------------------------------------------------------
module prefetch_txn_sequencer
    import prefetch_seq_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int MAX_RETRY      = 2,
    parameter int INIT_PULSE     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_start,
    input  logic                  cfg_abort,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    output logic                  txn_init,
    output logic [ADDR_WIDTH-1:0] txn_addr,
    input  logic                  txn_done,
    input  logic                  txn_error,
    output logic                  busy,
    output logic                  job_done,
    output logic [1:0]            job_status,
    output logic [CNT_WIDTH-1:0]  done_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int PW = (INIT_PULSE > 1) ? $clog2(INIT_PULSE) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    if (INIT_PULSE < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("prefetch_txn_sequencer: INIT_PULSE and TIMEOUT_CYCLES must be >= 1");
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    seq_state_e            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [ADDR_WIDTH-1:0] stride_q,   stride_d;
    logic [CNT_WIDTH-1:0]  count_q,    count_d;
    logic [CNT_WIDTH-1:0]  idx_q,      idx_d;      // 1-based index of current transaction
    logic [CNT_WIDTH-1:0]  done_cnt_q, done_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q,  err_cnt_d;
    logic [1:0]            status_q,   status_d;
    logic                  busy_q,     busy_d;
    logic                  job_done_q, job_done_d;
    logic [PW-1:0]         pulse_q,    pulse_d;
    logic [RW-1:0]         retry_q,    retry_d;
    logic                  abort_pend_q, abort_pend_d; // abort seen while a txn is outstanding
    logic                  done_rise;
    logic                  abort_now;

`ifdef PREFETCH_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]         wait_cnt_q, wait_cnt_d;
`endif

    prefetch_edge_det u_done_edge (
        .clk_i  (ACLK),
        .rst_i  (ARESET),
        .din_i  (txn_done),
        .rise_o (done_rise)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        stride_d     = stride_q;
        count_d      = count_q;
        idx_d        = idx_q;
        done_cnt_d   = done_cnt_q;
        err_cnt_d    = err_cnt_q;
        status_d     = status_q;
        busy_d       = busy_q;
        job_done_d   = 1'b0;
        pulse_d      = pulse_q;
        retry_d      = retry_q;
        abort_pend_d = abort_pend_q;
        abort_now    = abort_pend_q | cfg_abort;
`ifdef PREFETCH_SEQ_TIMEOUT_EN
        wait_cnt_d   = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    stride_d     = cfg_stride;
                    count_d      = cfg_count;
                    idx_d        = CNT_ONE;
                    done_cnt_d   = '0;
                    err_cnt_d    = '0;
                    status_d     = STATUS_OK;
                    busy_d       = 1'b1;
                    pulse_d      = '0;
                    retry_d      = '0;
                    abort_pend_d = 1'b0;
                    if (cfg_count == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        addr_d  = cfg_base_addr;
                        state_d = ST_LAUNCH;
                    end
                end
            end

            ST_LAUNCH: begin
                if (cfg_abort) begin
                    status_d = STATUS_ABORT;
                    pulse_d  = '0;
                    state_d  = ST_FINISH;
                end else if (pulse_q == PW'(INIT_PULSE - 1)) begin
                    pulse_d = '0;
                    state_d = ST_WAIT;
                end else begin
                    pulse_d = pulse_q + PW'(1);
                end
            end

            ST_WAIT: begin
                if (cfg_abort) begin
                    abort_pend_d = 1'b1;
                end
                if (done_rise) begin
                    abort_pend_d = 1'b0;
                    if (!txn_error) begin
                        done_cnt_d = sat_inc(done_cnt_q);
                        state_d    = abort_now ? ST_FINISH : ST_NEXT;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        // An abort cancels any remaining retries.
                        if (abort_now) begin
                            state_d = ST_FINISH;
                        end else begin
                            retry_d = retry_q + RW'(1);
                            state_d = ST_LAUNCH;
                        end
                    end else begin
                        err_cnt_d = sat_inc(err_cnt_q);
                        status_d  = status_q | STATUS_ERR;
                        state_d   = abort_now ? ST_FINISH : ST_NEXT;
                    end
                    if (abort_now) begin
                        status_d = STATUS_ABORT;
                    end
                end
`ifdef PREFETCH_SEQ_TIMEOUT_EN
                else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_cnt_d    = sat_inc(err_cnt_q);
                    status_d     = STATUS_TIMEOUT;
                    abort_pend_d = 1'b0;
                    state_d      = ST_FINISH;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
`endif
            end

            ST_NEXT: begin
                if (cfg_abort) begin
                    status_d = STATUS_ABORT;
                    state_d  = ST_FINISH;
                end else if (idx_q == count_q) begin
                    state_d = ST_FINISH;
                end else begin
                    addr_d  = addr_q + stride_q;   // wraps modulo 2^ADDR_WIDTH
                    idx_d   = idx_q + CNT_ONE;
                    retry_d = '0;
                    state_d = ST_LAUNCH;
                end
            end

            ST_FINISH: begin
                job_done_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            stride_q     <= '0;
            count_q      <= '0;
            idx_q        <= '0;
            done_cnt_q   <= '0;
            err_cnt_q    <= '0;
            status_q     <= STATUS_OK;
            busy_q       <= 1'b0;
            job_done_q   <= 1'b0;
            pulse_q      <= '0;
            retry_q      <= '0;
            abort_pend_q <= 1'b0;
`ifdef PREFETCH_SEQ_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            stride_q     <= stride_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            done_cnt_q   <= done_cnt_d;
            err_cnt_q    <= err_cnt_d;
            status_q     <= status_d;
            busy_q       <= busy_d;
            job_done_q   <= job_done_d;
            pulse_q      <= pulse_d;
            retry_q      <= retry_d;
            abort_pend_q <= abort_pend_d;
`ifdef PREFETCH_SEQ_TIMEOUT_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    // Decoded straight from state so the launch pulse can only exist in LAUNCH
    // and drops immediately on reset.
    assign txn_init   = (state_q == ST_LAUNCH);
    assign txn_addr   = addr_q;
    assign busy       = busy_q;
    assign job_done   = job_done_q;
    assign job_status = status_q;
    assign done_cnt   = done_cnt_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_prefetch_txn_sequencer.sv
module tb_prefetch_txn_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_abort;
    logic [31:0] cfg_base_addr, cfg_stride;
    logic [15:0] cfg_count;
    logic        txn_init;
    logic [31:0] txn_addr;
    logic        txn_done, txn_error;
    logic        busy, job_done;
    logic [1:0]  job_status;
    logic [15:0] done_cnt, err_cnt;

    int total = 0;
    int bad   = 0;

    // master model / monitor state
    int          launches = 0;
    int          jd_cnt   = 0;
    logic [31:0] launch_addr [0:63];
    int          pulse_w     [0:63];
    bit          err_plan    [0:63];
    bit          mute = 1'b0;
    int          l0;
    int          j0;

    always #5 clk = ~clk;

    prefetch_txn_sequencer dut (
        .ACLK          (clk),
        .ARESET        (rst),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_base_addr (cfg_base_addr),
        .cfg_stride    (cfg_stride),
        .cfg_count     (cfg_count),
        .txn_init      (txn_init),
        .txn_addr      (txn_addr),
        .txn_done      (txn_done),
        .txn_error     (txn_error),
        .busy          (busy),
        .job_done      (job_done),
        .job_status    (job_status),
        .done_cnt      (done_cnt),
        .err_cnt       (err_cnt)
    );

    // Behavioural AXI master: records each launch, then 3 cycles after
    // txn_init falls raises TXN_DONE for 2 cycles with the planned ERROR.
    initial begin : master
        int  cur;
        int  wcnt;
        int  hold;
        bit  armed;
        bit  phase;
        bit  init_prev;
        cur = 0; wcnt = 0; hold = 0; armed = 0; phase = 0; init_prev = 0;
        txn_done  = 1'b0;
        txn_error = 1'b0;
        foreach (err_plan[i]) err_plan[i] = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (job_done) jd_cnt++;
            if (txn_init && !init_prev && launches < 64) begin
                cur = launches;
                launch_addr[cur] = txn_addr;
                pulse_w[cur] = 0;
                launches++;
                armed = 1; wcnt = 0;
            end
            if (txn_init) pulse_w[cur]++;
            init_prev = txn_init;
            if (phase) begin
                hold++;
                if (hold == 2) begin
                    txn_done = 1'b0; txn_error = 1'b0; phase = 0;
                end
            end else if (armed && !txn_init && !mute) begin
                wcnt++;
                if (wcnt == 3) begin
                    txn_done = 1'b1; txn_error = err_plan[cur];
                    armed = 0; phase = 1; hold = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] b, input logic [31:0] s, input logic [15:0] c);
        l0 = launches;
        j0 = jd_cnt;
        cfg_base_addr = b; cfg_stride = s; cfg_count = c;
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
    endtask

    task automatic wait_job(input string tag, input int limit);
        int n;
        n = 0;
        while (jd_cnt == j0 && n < limit) begin
            tick(1);
            n++;
        end
        chk({tag, "_job_done_seen"}, 64'(jd_cnt > j0), 64'd1);
        tick(4);
        chk({tag, "_job_done_once"}, 64'(jd_cnt - j0), 64'd1);
        chk({tag, "_busy_clear"}, 64'(busy), 64'd0);
    endtask

    initial begin : stim
        int n;
        rst = 1'b1;
        cfg_start = 0; cfg_abort = 0;
        cfg_base_addr = '0; cfg_stride = '0; cfg_count = '0;
        tick(3);
        chk("rst_busy",     64'(busy), 64'd0);
        chk("rst_txn_init", 64'(txn_init), 64'd0);
        chk("rst_job_done", 64'(job_done), 64'd0);
        chk("rst_txn_addr", 64'(txn_addr), 64'd0);
        chk("rst_status",   64'(job_status), 64'd0);
        chk("rst_done_cnt", 64'(done_cnt), 64'd0);
        chk("rst_err_cnt",  64'(err_cnt), 64'd0);
        rst = 1'b0;
        tick(2);

        // 1: four clean transactions
        start_job(32'h4000_0000, 32'h10, 16'd4);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_job("t1", 300);
        chk("t1_launches", 64'(launches - l0), 64'd4);
        chk("t1_addr0", 64'(launch_addr[l0]),   64'h4000_0000);
        chk("t1_addr1", 64'(launch_addr[l0+1]), 64'h4000_0010);
        chk("t1_addr2", 64'(launch_addr[l0+2]), 64'h4000_0020);
        chk("t1_addr3", 64'(launch_addr[l0+3]), 64'h4000_0030);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_pulse%0d", i), 64'(pulse_w[l0+i]), 64'd2);
        chk("t1_done_cnt", 64'(done_cnt), 64'd4);
        chk("t1_err_cnt",  64'(err_cnt), 64'd0);
        chk("t1_status",   64'(job_status), 64'd0);

        // 2: txn 2 fails twice, succeeds on last retry
        err_plan[launches+1] = 1'b1;
        err_plan[launches+2] = 1'b1;
        start_job(32'h0000_1000, 32'h100, 16'd3);
        wait_job("t2", 400);
        chk("t2_launches", 64'(launches - l0), 64'd5);
        chk("t2_addr1", 64'(launch_addr[l0+1]), 64'h1100);
        chk("t2_addr2", 64'(launch_addr[l0+2]), 64'h1100);
        chk("t2_addr3", 64'(launch_addr[l0+3]), 64'h1100);
        chk("t2_addr4", 64'(launch_addr[l0+4]), 64'h1200);
        chk("t2_done_cnt", 64'(done_cnt), 64'd3);
        chk("t2_err_cnt",  64'(err_cnt), 64'd0);
        chk("t2_status",   64'(job_status), 64'd0);

        // 3: txn 2 fails on every attempt
        err_plan[launches+1] = 1'b1;
        err_plan[launches+2] = 1'b1;
        err_plan[launches+3] = 1'b1;
        start_job(32'h0000_2000, 32'h40, 16'd2);
        wait_job("t3", 400);
        chk("t3_launches", 64'(launches - l0), 64'd4);
        chk("t3_addr3", 64'(launch_addr[l0+3]), 64'h2040);
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);
        chk("t3_err_cnt",  64'(err_cnt), 64'd1);
        chk("t3_status",   64'(job_status), 64'd1);

        // 4: abort while waiting on txn 2 of 5; start during busy ignored
        start_job(32'h0000_3000, 32'h8, 16'd5);
        n = 0;
        while (!((launches - l0) >= 2 && !txn_init) && n < 200) begin
            tick(1);
            n++;
        end
        chk("t4_reached_wait2", 64'(n < 200), 64'd1);
        cfg_abort = 1'b1;
        tick(1);
        cfg_abort = 1'b0;
        cfg_base_addr = 32'h9999_0000; cfg_count = 16'd1;
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
        wait_job("t4", 200);
        chk("t4_launches", 64'(launches - l0), 64'd2);
        chk("t4_done_cnt", 64'(done_cnt), 64'd2);
        chk("t4_status",   64'(job_status), 64'd2);
        tick(10);
        chk("t4_no_restart", 64'(launches - l0), 64'd2);

        // 5: address wrap
        start_job(32'hFFFF_FFF0, 32'h10, 16'd2);
        wait_job("t5", 200);
        chk("t5_addr0", 64'(launch_addr[l0]),   64'hFFFF_FFF0);
        chk("t5_addr1", 64'(launch_addr[l0+1]), 64'h0000_0000);
        chk("t5_done_cnt", 64'(done_cnt), 64'd2);

        // 6: empty job, job_done two cycles after start
        start_job(32'h0000_5000, 32'h10, 16'd0);
        chk("t6_jd_cycle1", 64'(job_done), 64'd0);
        chk("t6_busy_cycle1", 64'(busy), 64'd1);
        tick(1);
        chk("t6_jd_cycle2", 64'(job_done), 64'd1);
        chk("t6_done_cnt", 64'(done_cnt), 64'd0);
        tick(3);
        chk("t6_no_launch", 64'(launches - l0), 64'd0);
        chk("t6_status", 64'(job_status), 64'd0);

        // 7: reset mid-WAIT
        mute = 1'b1;
        start_job(32'h0000_5000, 32'h10, 16'd2);
        tick(5);
        chk("t7_in_wait_busy", 64'(busy), 64'd1);
        chk("t7_in_wait_addr", 64'(txn_addr), 64'h5000);
        rst = 1'b1;
        #1;
        chk("t7_rst_busy", 64'(busy), 64'd0);
        chk("t7_rst_addr", 64'(txn_addr), 64'd0);
        chk("t7_rst_init", 64'(txn_init), 64'd0);
        tick(2);
        rst = 1'b0;
        tick(5);
        chk("t7_no_job_done", 64'(jd_cnt - j0), 64'd0);

`ifdef PREFETCH_SEQ_TIMEOUT_EN
        // 8: watchdog on a master that never completes
        start_job(32'h0000_6000, 32'h10, 16'd1);
        wait_job("t8", 1500);
        chk("t8_status",   64'(job_status), 64'd3);
        chk("t8_err_cnt",  64'(err_cnt), 64'd1);
        chk("t8_done_cnt", 64'(done_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
